// File: rtl/tlb_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_walk_ctrl
// Description : Page-table walker / TLB refill sequencer for ARM short-format
//               descriptors. Fetches L1 (and L2 for coarse tables) over a
//               single-beat read port, then writes a TLB entry or faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_walk_ctrl #(
  parameter int TBITS         = 20,
  parameter int TLB_WORD_SIZE = TBITS + 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic                     i_miss,
  input  logic [31:0]              i_virt_adr,
  input  logic [17:0]              i_ttb,
  input  logic                     i_flush,
  output logic                     o_mem_req,
  output logic [31:0]              o_mem_adr,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_rdata,
  output logic                     o_tlb_we,
  output logic [TBITS-1:0]         o_virt_tag,
  output logic [TLB_WORD_SIZE-1:0] o_table_entry,
  output logic                     o_busy,
  output logic                     o_fault,
  output logic [3:0]               o_fault_status,
  output logic [31:0]              o_fault_adr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_L1_REQ = 3'd1;
  localparam logic [2:0] S_L2_REQ = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  localparam logic [3:0] C_FSR_L1 = 4'b0101;
  localparam logic [3:0] C_FSR_L2 = 4'b0111;

  logic [2:0]               r_state;
  logic [31:0]              r_va;
  logic [3:0]               r_domain;
  logic [31:0]              r_mem_adr;
  logic [TBITS-1:0]         r_virt_tag;
  logic [TLB_WORD_SIZE-1:0] r_entry;
  logic [3:0]               r_fsr;
  logic [31:0]              r_fault_adr;

  logic [31:0]      w_d;
  logic [31:0]      w_l1_adr;
  logic [31:0]      w_l2_adr;
  logic [TBITS-1:0] w_sec_tag;
  logic [TBITS-1:0] w_page_tag;
  logic             w_start;
  logic             w_unused_ok;

  assign w_d         = i_mem_rdata;
  assign w_l1_adr    = {i_ttb, i_virt_adr[31:20], 2'b00};
  assign w_l2_adr    = {w_d[31:10], r_va[19:12], 2'b00};
  assign w_sec_tag   = {w_d[31:20], r_va[19:12]};
  // Descriptor type 01 is a 64 KB large page, 10 a 4 KB small page.
  assign w_page_tag  = w_d[0] ? {w_d[31:16], r_va[15:12]} : w_d[31:12];
  assign w_start     = i_enable & i_miss & ~i_flush;
  assign w_unused_ok = w_d[9];

  // Walk sequencer: state plus every captured descriptor field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_va        <= '0;
      r_domain    <= '0;
      r_mem_adr   <= '0;
      r_virt_tag  <= '0;
      r_entry     <= '0;
      r_fsr       <= '0;
      r_fault_adr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_va      <= i_virt_adr;
            r_mem_adr <= w_l1_adr;
            r_fsr     <= '0;
            r_state   <= S_L1_REQ;
          end
        end
        S_L1_REQ: begin
          if (i_mem_ack) begin
            if (i_flush) begin
              r_state <= S_IDLE;
            end else begin
              case (w_d[1:0])
                2'b01: begin
                  r_domain  <= w_d[8:5];
                  r_mem_adr <= w_l2_adr;
                  r_state   <= S_L2_REQ;
                end
                2'b10: begin
                  r_entry    <= {w_sec_tag, w_d[3], w_d[2], w_d[11:10], w_d[8:5], 1'b1};
                  r_virt_tag <= r_va[31:12];
                  r_state    <= S_FILL;
                end
                default: begin
                  r_fsr       <= C_FSR_L1;
                  r_fault_adr <= r_va;
                  r_state     <= S_FAULT;
                end
              endcase
            end
          end else if (i_flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_L2_REQ: begin
          if (i_mem_ack) begin
            if (i_flush) begin
              r_state <= S_IDLE;
            end else if (w_d[1:0] == 2'b01 || w_d[1:0] == 2'b10) begin
              r_entry    <= {w_page_tag, w_d[3], w_d[2], w_d[5:4], r_domain, 1'b1};
              r_virt_tag <= r_va[31:12];
              r_state    <= S_FILL;
            end else begin
              r_fsr       <= C_FSR_L2;
              r_fault_adr <= r_va;
              r_state     <= S_FAULT;
            end
          end else if (i_flush) begin
            r_state <= S_DRAIN;
          end
        end
        // An issued read cannot be withdrawn; wait for its ack and drop it.
        S_DRAIN: begin
          if (i_mem_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_req      = (r_state == S_L1_REQ) || (r_state == S_L2_REQ) || (r_state == S_DRAIN);
  assign o_mem_adr      = r_mem_adr;
  assign o_tlb_we       = (r_state == S_FILL);
  assign o_fault        = (r_state == S_FAULT);
  assign o_busy         = (r_state != S_IDLE);
  assign o_virt_tag     = r_virt_tag;
  assign o_table_entry  = r_entry;
  assign o_fault_status = r_fsr;
  assign o_fault_adr    = r_fault_adr;

endmodule
`default_nettype wire

// File: tb/tb_tlb_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_walk_ctrl
// Description : Directed bench for tlb_walk_ctrl: section, small/large page,
//               faults, flush/drain and asynchronous reset mid-walk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_walk_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, miss, flush, ack;
  logic [31:0] va, rdata;
  logic [17:0] ttb;
  logic        mem_req, tlb_we, busy, fault;
  logic [31:0] mem_adr, fault_adr;
  logic [19:0] virt_tag;
  logic [28:0] entry;
  logic [3:0]  fsr;

  int checks   = 0;
  int failures = 0;

  tlb_walk_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (enable),
    .i_miss         (miss),
    .i_virt_adr     (va),
    .i_ttb          (ttb),
    .i_flush        (flush),
    .o_mem_req      (mem_req),
    .o_mem_adr      (mem_adr),
    .i_mem_ack      (ack),
    .i_mem_rdata    (rdata),
    .o_tlb_we       (tlb_we),
    .o_virt_tag     (virt_tag),
    .o_table_entry  (entry),
    .o_busy         (busy),
    .o_fault        (fault),
    .o_fault_status (fsr),
    .o_fault_adr    (fault_adr)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; miss = 1'b0; flush = 1'b0; ack = 1'b0;
    va = '0; rdata = '0; ttb = 18'h00010;
    #12;
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_busy",   {31'd0, busy},    32'd0);
    chk("rst_we",     {31'd0, tlb_we},  32'd0);
    chk("rst_fault",  {31'd0, fault},   32'd0);
    chk("rst_adr",    mem_adr,          32'd0);
    chk("rst_entry",  {3'd0, entry},    32'd0);
    chk("rst_fsr",    {28'd0, fsr},     32'd0);
    tick();
    reset = 1'b1;

    // ---------------- Section ----------------
    enable = 1'b1; miss = 1'b1; va = 32'h1234_5678;
    tick(); miss = 1'b0;
    chk("sec_req",  {31'd0, mem_req}, 32'd1);
    chk("sec_busy", {31'd0, busy},    32'd1);
    chk("sec_adr",  mem_adr,          32'h0004_048C);
    ack = 1'b1; rdata = 32'hABC0_0C2E;
    tick(); ack = 1'b0;
    chk("sec_we",    {31'd0, tlb_we},  32'd1);
    chk("sec_busy2", {31'd0, busy},    32'd1);
    chk("sec_req2",  {31'd0, mem_req}, 32'd0);
    chk("sec_vtag",  {12'd0, virt_tag}, 32'h0001_2345);
    chk("sec_entry", {3'd0, entry}, {3'd0, 20'hABC45, 1'b1, 1'b1, 2'b11, 4'h1, 1'b1});
    tick();
    chk("sec_we_off", {31'd0, tlb_we}, 32'd0);
    chk("sec_idle",   {31'd0, busy},   32'd0);

    // ---------------- Small page, 2 wait cycles on L2 ----------------
    miss = 1'b1;
    tick(); miss = 1'b0;
    ack = 1'b1; rdata = 32'h0020_0021;
    tick(); ack = 1'b0; rdata = '0;
    chk("sp_l2req", {31'd0, mem_req}, 32'd1);
    chk("sp_l2adr", mem_adr, 32'h0020_0114);
    tick();
    chk("sp_wait1", {30'd0, mem_req, tlb_we}, 32'd2);
    tick();
    chk("sp_wait2_adr", mem_adr, 32'h0020_0114);
    ack = 1'b1; rdata = 32'h5555_503E;
    tick(); ack = 1'b0;
    chk("sp_we",    {31'd0, tlb_we}, 32'd1);
    chk("sp_entry", {3'd0, entry}, {3'd0, 20'h55555, 1'b1, 1'b1, 2'b11, 4'h1, 1'b1});
    tick();

    // ---------------- L1 fault ----------------
    miss = 1'b1; va = 32'hDEAD_B000;
    tick(); miss = 1'b0;
    ack = 1'b1; rdata = 32'h0000_0000;
    tick(); ack = 1'b0;
    chk("f1_fault", {31'd0, fault},  32'd1);
    chk("f1_we",    {31'd0, tlb_we}, 32'd0);
    chk("f1_fsr",   {28'd0, fsr},    32'h5);
    chk("f1_adr",   fault_adr,       32'hDEAD_B000);
    tick();
    chk("f1_pulse", {31'd0, fault},  32'd0);
    chk("f1_held",  {28'd0, fsr},    32'h5);

    // ---------------- L2 fault (type 11) ----------------
    miss = 1'b1; va = 32'h1234_5678;
    tick(); miss = 1'b0;
    ack = 1'b1; rdata = 32'h0020_0021;
    tick();
    rdata = 32'h0000_0003;
    tick(); ack = 1'b0;
    chk("f2_fault", {31'd0, fault}, 32'd1);
    chk("f2_fsr",   {28'd0, fsr},   32'h7);
    tick();

    // ---------------- Flush in L2_REQ, ack 3 cycles later ----------------
    miss = 1'b1;
    tick(); miss = 1'b0;
    ack = 1'b1; rdata = 32'h0020_0021;
    tick(); ack = 1'b0;
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("fl_req1",  {31'd0, mem_req}, 32'd1);
    chk("fl_busy1", {31'd0, busy},    32'd1);
    tick();
    chk("fl_req2",  {31'd0, mem_req}, 32'd1);
    tick();
    chk("fl_req3",  {30'd0, mem_req, tlb_we | fault}, 32'd2);
    ack = 1'b1; rdata = 32'h5555_503E;
    tick(); ack = 1'b0;
    chk("fl_idle",  {29'd0, busy, mem_req, tlb_we | fault}, 32'd0);
    miss = 1'b1;
    tick(); miss = 1'b0;
    chk("fl_next",  {31'd0, mem_req}, 32'd1);
    chk("fl_nadr",  mem_adr, 32'h0004_048C);

    // Flush together with ack: straight to IDLE, nothing written
    flush = 1'b1; ack = 1'b1; rdata = 32'hABC0_0C2E;
    tick(); flush = 1'b0; ack = 1'b0;
    chk("fa_idle",  {29'd0, busy, mem_req, tlb_we}, 32'd0);

    // ---------------- Async reset mid-walk ----------------
    miss = 1'b1;
    tick(); miss = 1'b0;
    chk("ar_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_drop", {30'd0, mem_req, busy}, 32'd0);
    tick();
    reset = 1'b1; enable = 1'b0; miss = 1'b1;
    tick();
    chk("ar_dis", {30'd0, mem_req, busy}, 32'd0);
    enable = 1'b1;
    tick(); miss = 1'b0;
    chk("ar_fresh", {31'd0, mem_req}, 32'd1);
    chk("ar_adr",   mem_adr, 32'h0004_048C);

    // ---------------- Large page, VA[15:12]=9 ----------------
    ack = 1'b1; rdata = 32'hABC0_0C2E;
    tick(); ack = 1'b0;
    tick();
    va = 32'h1234_9678; miss = 1'b1;
    tick(); miss = 1'b0;
    ack = 1'b1; rdata = 32'h0020_0021;
    tick();
    chk("lp_l2adr", mem_adr, 32'h0020_0124);
    rdata = 32'h7777_0001;
    tick(); ack = 1'b0;
    chk("lp_we",    {31'd0, tlb_we}, 32'd1);
    chk("lp_vtag",  {12'd0, virt_tag}, 32'h0001_2349);
    chk("lp_entry", {3'd0, entry}, {3'd0, 20'h77779, 1'b0, 1'b0, 2'b00, 4'h1, 1'b1});
    tick();
    chk("lp_done",  {30'd0, busy, tlb_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
